// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

    localparam int WORD_W        = 32;
    localparam int DEFAULT_DEPTH = 1048576;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2,
        CHECK = 2'd3
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Program loader: streams a host word image into imem/dmem from word address 0
// upward and holds the core in reset until the image is complete.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to treat the last beat as
// a 32-bit wrap-around checksum of the payload, verified in a one-cycle CHECK state.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] FULL = DEPTH[ADDR_W:0];

    loader_state_e state_q;
    loader_state_e state_d;
    logic          do_write;
    logic          clear;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic              take_chk;
    logic [WORD_W-1:0] sum_q;
    logic [WORD_W-1:0] chk_q;
`endif

    // Status outputs decode directly from the state register.
    assign in_ready   = (state_q == LOAD) && !reset;
    assign cpu_reset  = (state_q != RUN);
    assign load_done  = (state_q == RUN);
    assign load_error = (state_q == ERROR);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        clear    = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        take_chk = 1'b0;
`endif
        case (state_q)
            LOAD: begin
                if (in_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    // The checksum beat occupies no memory, so it is exempt from overflow.
                    if (in_last) begin
                        take_chk = 1'b1;
                        state_d  = CHECK;
                    end else if (word_count == FULL) begin
                        state_d = ERROR;
                    end else begin
                        do_write = 1'b1;
                    end
`else
                    if (word_count == FULL) begin
                        state_d = ERROR;
                    end else begin
                        do_write = 1'b1;
                        if (in_last) begin
                            state_d = RUN;
                        end
                    end
`endif
                end
            end
            RUN, ERROR: begin
                if (restart) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if ((word_count != '0) && (sum_q == chk_q)) begin
                    state_d = RUN;
                end else begin
                    state_d = ERROR;
                end
            end
`endif
            default: state_d = LOAD;
        endcase
    end

    // Write port registers and payload word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            mem_we <= do_write;
            if (do_write) begin
                mem_addr   <= word_count[ADDR_W-1:0];
                mem_wdata  <= in_data;
                word_count <= word_count + (ADDR_W+1)'(1);
            end
            if (clear) begin
                word_count <= '0;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running payload sum and captured checksum word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            chk_q <= '0;
        end else begin
            if (clear) begin
                sum_q <= '0;
            end else if (do_write) begin
                sum_q <= sum_q + in_data;
            end
            if (take_chk) begin
                chk_q <= in_data;
            end
        end
    end
`endif

endmodule
